capture_sequencer: RTL and testbench

Acquisition controller between the lock-in result stream and the 8192×32 capture FIFO's Avalon-ST sink. Software arms a capture over an Avalon-MM register slave. A software or external trigger then starts it. The block forwards a programmed number of (optionally decimated) samples into the FIFO, flags any sample lost to FIFO backpressure, and raises an interrupt when the capture completes.

---
 rtl/capture_sequencer.sv | 176 +++++++++++++++++
 tb/tb_capture_sequencer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// capture_sequencer: arms on START, waits for a software or external trigger,
// then streams NSAMPLES (optionally decimated) samples into the capture FIFO.
// Build option: CAPTURE_SEQ_DECIMATION_EN enables the DECIM register and the
// decimation counter; without it every in_valid sample is kept.
// Ports: clock, reset (synchronous, active-high);
//   in_data/in_valid   free-running sample stream, no backpressure;
//   ext_trig           external trigger level (rising edge triggers);
//   out_data/out_valid registered one-cycle strobe to the FIFO sink;
//   out_ready          FIFO sink ready;
//   address/write/read/writedata/readdata  Avalon-MM register slave;
//   irq                level interrupt, high in DONE until acknowledged.
module capture_sequencer #(
    parameter int DATA_W      = 32,
    parameter int MAX_SAMPLES = 8192,
    parameter int CNT_W       = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              ext_trig,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [1:0]        address,
    input  logic              write,
    input  logic              read,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] nsamples;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] nsamp_wr;
    logic             ext_en;
    logic             overflow;
    logic             done;
    logic             ext_cur;
    logic             ext_prev;
    logic             wr_ctrl;
    logic             wr_nsamp;
    logic             do_start;
    logic             do_abort;
    logic             do_ack;
    logic             trig;
    logic             arm;
    logic             step;
    logic             keep;
    logic             busy;
    logic [31:0]      decim_rd;

    assign wr_ctrl  = write && (address == 2'd0);
    assign wr_nsamp = write && (address == 2'd1)
                      && (state != S_CAPTURE);
    assign do_abort = wr_ctrl && writedata[1];
    assign do_start = wr_ctrl && writedata[0];
    assign do_ack   = wr_ctrl && writedata[3];
    assign trig     = (wr_ctrl && writedata[2])
                      || (ext_en && ext_cur && !ext_prev);

    // START is only honoured from IDLE or DONE, and never alongside ABORT.
    assign arm  = !do_abort && do_start
                  && ((state == S_IDLE) || (state == S_DONE));
    assign step = !do_abort && (state == S_CAPTURE) && in_valid;

    assign count_inc = count + 1'b1;
    assign nsamp_wr  = (writedata > 32'(MAX_SAMPLES))
                       ? CNT_W'(MAX_SAMPLES)
                       : writedata[CNT_W-1:0];

    assign busy = (state == S_ARMED) || (state == S_CAPTURE);
    assign irq  = (state == S_DONE);

`ifdef CAPTURE_SEQ_DECIMATION_EN
    logic [15:0] decim;
    logic [15:0] dec_cnt;

    assign keep     = (dec_cnt == 16'd0);
    assign decim_rd = {16'd0, decim};

    // Counter reloads on every keep, whether or not the FIFO took it.
    always_ff @(posedge clock) begin
        if (reset) begin
            decim   <= '0;
            dec_cnt <= '0;
        end else begin
            if (write && (address == 2'd2) && (state != S_CAPTURE))
                decim <= writedata[15:0];
            if (arm)
                dec_cnt <= '0;
            else if (step)
                dec_cnt <= keep ? decim : dec_cnt - 1'b1;
        end
    end
`else
    assign keep     = 1'b1;
    assign decim_rd = 32'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            nsamples  <= '0;
            count     <= '0;
            ext_en    <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            ext_cur   <= 1'b0;
            ext_prev  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            ext_cur   <= ext_trig;
            ext_prev  <= ext_cur;
            if (wr_ctrl)
                ext_en <= writedata[4];
            if (wr_nsamp)
                nsamples <= nsamp_wr;

            if (do_abort) begin
                state <= S_IDLE;
            end else if (arm) begin
                state    <= S_ARMED;
                count    <= '0;
                overflow <= 1'b0;
                done     <= 1'b0;
            end else if ((state == S_ARMED) && trig) begin
                if (nsamples == '0) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else begin
                    state <= S_CAPTURE;
                end
            end else if ((state == S_DONE) && do_ack) begin
                state <= S_IDLE;
            end

            if (step && keep) begin
                if (out_ready) begin
                    out_valid <= 1'b1;
                    out_data  <= in_data;
                    count     <= count_inc;
                    if (count_inc == nsamples) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (read) begin
            unique case (address)
                2'd0: readdata = {26'd0, ext_en, overflow,
                                  done, state, busy};
                2'd1: readdata = 32'(nsamples);
                2'd2: readdata = decim_rd;
                default: readdata = 32'(count);
            endcase
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: randomized and directed checks of capture_sequencer
// against a sample-list reference model of the capture rules.
module tb_capture_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        ext_trig = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

`ifdef CAPTURE_SEQ_DECIMATION_EN
    localparam bit DEC_ON = 1'b1;
`else
    localparam bit DEC_ON = 1'b0;
`endif

    logic        v_arr[64];
    logic        r_arr[64];
    logic [31:0] d_arr[64];
    logic [31:0] rd;

    always #5 clock = ~clock;

    capture_sequencer #(
        .DATA_W(32),
        .MAX_SAMPLES(8192),
        .CNT_W(14)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .ext_trig(ext_trig),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .address(address),
        .write(write),
        .read(read),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq)
    );

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clock);
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        #1;
        d    = readdata;
        read = 1'b0;
    endtask

    // Model: the k-th valid sample of a capture is kept when k mod (D+1)
    // is 0; kept+ready samples are forwarded until N have been forwarded.
    task automatic run_capture(input int n, input int d, input int len,
                               input string tag, output int mcount,
                               output bit movf, output bit mdone);
        int          deff;
        int          kidx;
        bit          exp_ov;
        logic [31:0] exp_od;
        deff   = DEC_ON ? d : 0;
        kidx   = 0;
        mcount = 0;
        movf   = 1'b0;
        mdone  = 1'b0;
        exp_od = '0;
        cpu_write(2'd1, n);
        cpu_write(2'd2, d);
        cpu_write(2'd0, 32'h1);
        cpu_write(2'd0, 32'h4);
        for (int i = 0; i < len; i++) begin
            in_valid  = v_arr[i];
            in_data   = d_arr[i];
            out_ready = r_arr[i];
            exp_ov    = 1'b0;
            if (!mdone && v_arr[i]) begin
                if (kidx % (deff + 1) == 0) begin
                    if (r_arr[i]) begin
                        exp_ov = 1'b1;
                        exp_od = d_arr[i];
                        mcount++;
                        if (mcount == n) mdone = 1'b1;
                    end else begin
                        movf = 1'b1;
                    end
                end
                kidx++;
            end
            @(negedge clock);
            vectors++;
            if (out_valid !== exp_ov) begin
                miscompares++;
                $display("FAIL %s out_valid cyc %0d: got %b want %b",
                         tag, i, out_valid, exp_ov);
            end
            if (exp_ov) begin
                vectors++;
                if (out_data !== exp_od) begin
                    miscompares++;
                    $display("FAIL %s out_data cyc %0d: got %h want %h",
                             tag, i, out_data, exp_od);
                end
            end
            vectors++;
            if (irq !== mdone) begin
                miscompares++;
                $display("FAIL %s irq cyc %0d: got %b want %b",
                         tag, i, irq, mdone);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cpu_read(2'd3, rd);
        vectors++;
        if (rd !== 32'(mcount)) begin
            miscompares++;
            $display("FAIL %s count: got %0d want %0d", tag, rd, mcount);
        end
        cpu_read(2'd0, rd);
        vectors++;
        if (rd[4:1] !== {movf, mdone, (mdone ? 2'd3 : 2'd2)}) begin
            miscompares++;
            $display("FAIL %s ctrl ovf/done/state: got %b want %b",
                     tag, rd[4:1], {movf, mdone, (mdone ? 2'd3 : 2'd2)});
        end
    endtask

    task automatic fill(input int len, input int vpct, input int rpct);
        for (int i = 0; i < 64; i++) begin
            v_arr[i] = (i < len) && ($urandom_range(99, 0) < vpct);
            r_arr[i] = ($urandom_range(99, 0) < rpct);
            d_arr[i] = $urandom;
        end
    endtask

    task automatic test_reset();
        ext_trig = 1'b1;
        reset    = 1'b1;
        repeat (3) @(negedge clock);
        vectors++;
        if ({out_valid, irq, out_data, readdata} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset outputs: got ov=%b irq=%b od=%h rd=%h want 0",
                     out_valid, irq, out_data, readdata);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        for (int a = 0; a < 4; a++) begin
            cpu_read(a[1:0], rd);
            vectors++;
            if (rd !== 32'd0) begin
                miscompares++;
                $display("FAIL reset reg%0d: got %h want 0", a, rd);
            end
        end
        ext_trig = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int mc;
        bit mo;
        bit md;
        for (int i = 0; i < 64; i++) begin
            v_arr[i] = (i < 6);
            r_arr[i] = 1'b1;
            d_arr[i] = i + 1;
        end
        run_capture(4, 0, 8, "basic", mc, mo, md);
        cpu_write(2'd0, 32'h8);
        cpu_read(2'd0, rd);
        vectors++;
        if (rd[3:0] !== 4'b1000 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL ack ctrl: got %b irq=%b want 1000 irq=0",
                     rd[3:0], irq);
        end
    endtask

    task automatic test_decim();
        int mc;
        bit mo;
        bit md;
        for (int i = 0; i < 64; i++) begin
            v_arr[i] = (i < 9);
            r_arr[i] = 1'b1;
            d_arr[i] = i;
        end
        run_capture(3, 2, 11, "decim", mc, mo, md);
        cpu_read(2'd2, rd);
        vectors++;
        if (rd !== (DEC_ON ? 32'd2 : 32'd0)) begin
            miscompares++;
            $display("FAIL decim reg: got %0d want %0d", rd,
                     DEC_ON ? 2 : 0);
        end
        cpu_write(2'd0, 32'h2);
    endtask

    task automatic test_overflow();
        int mc;
        bit mo;
        bit md;
        for (int i = 0; i < 64; i++) begin
            v_arr[i] = (i < 12);
            r_arr[i] = !(i == 3 || i == 4);
            d_arr[i] = 32'h100 + i;
        end
        run_capture(8, 0, 13, "overflow", mc, mo, md);
        cpu_write(2'd0, 32'h2);
    endtask

    task automatic test_back_to_back();
        int mc;
        bit mo;
        bit md;
        fill(20, 100, 100);
        run_capture(16, 0, 20, "b2b", mc, mo, md);
        cpu_write(2'd0, 32'h2);
    endtask

    task automatic test_random();
        int mc;
        bit mo;
        bit md;
        for (int it = 0; it < 8; it++) begin
            fill(48, 70, 85);
            run_capture($urandom_range(10, 1), $urandom_range(3, 0), 50,
                        $sformatf("rand%0d", it), mc, mo, md);
            cpu_write(2'd0, 32'h2);
            cpu_read(2'd0, rd);
            vectors++;
            if (rd[2:0] !== 3'b000 || irq !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d abort: got st=%b irq=%b want 000/0",
                         it, rd[2:0], irq);
            end
        end
    endtask

    task automatic test_ext_trig();
        cpu_write(2'd1, 5);
        cpu_write(2'd0, 32'h4);
        cpu_read(2'd0, rd);
        vectors++;
        if (rd[2:1] !== 2'd0) begin
            miscompares++;
            $display("FAIL swtrig idle: got state %0d want 0", rd[2:1]);
        end
        ext_trig = 1'b1;
        repeat (2) @(negedge clock);
        cpu_write(2'd0, 32'h11);
        repeat (3) @(negedge clock);
        cpu_read(2'd0, rd);
        vectors++;
        if (rd[5:0] !== 6'b100011) begin
            miscompares++;
            $display("FAIL ext stuck: got %b want 100011", rd[5:0]);
        end
        ext_trig = 1'b0;
        repeat (2) @(negedge clock);
        ext_trig = 1'b1;
        @(negedge clock);
        cpu_read(2'd0, rd);
        vectors++;
        if (rd[2:1] !== 2'd1) begin
            miscompares++;
            $display("FAIL ext edge early: got state %0d want 1", rd[2:1]);
        end
        @(negedge clock);
        cpu_read(2'd0, rd);
        vectors++;
        if (rd[2:1] !== 2'd2) begin
            miscompares++;
            $display("FAIL ext edge capture: got state %0d want 2",
                     rd[2:1]);
        end
        cpu_write(2'd0, 32'h2);
        ext_trig = 1'b0;
    endtask

    task automatic test_abort();
        int mc;
        bit mo;
        bit md;
        for (int i = 0; i < 64; i++) begin
            v_arr[i] = (i < 3);
            r_arr[i] = 1'b1;
            d_arr[i] = 32'hA0 + i;
        end
        run_capture(6, 1, 3, "abort", mc, mo, md);
        cpu_write(2'd1, 2);
        cpu_write(2'd2, 7);
        cpu_read(2'd1, rd);
        vectors++;
        if (rd !== 32'd6) begin
            miscompares++;
            $display("FAIL nsamp locked: got %0d want 6", rd);
        end
        cpu_read(2'd2, rd);
        vectors++;
        if (rd !== (DEC_ON ? 32'd1 : 32'd0)) begin
            miscompares++;
            $display("FAIL decim locked: got %0d want %0d", rd,
                     DEC_ON ? 1 : 0);
        end
        cpu_write(2'd0, 32'h3);
        cpu_read(2'd0, rd);
        vectors++;
        if (rd[2:0] !== 3'b000 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL abort+start: got st=%b irq=%b want 000/0",
                     rd[2:0], irq);
        end
        cpu_read(2'd3, rd);
        vectors++;
        if (rd !== 32'(mc)) begin
            miscompares++;
            $display("FAIL abort count: got %0d want %0d", rd, mc);
        end
        cpu_write(2'd1, 9000);
        cpu_read(2'd1, rd);
        vectors++;
        if (rd !== 32'd8192) begin
            miscompares++;
            $display("FAIL nsamp sat: got %0d want 8192", rd);
        end
    endtask

    task automatic test_zero();
        cpu_write(2'd1, 0);
        cpu_write(2'd0, 32'h1);
        cpu_write(2'd0, 32'h4);
        cpu_read(2'd0, rd);
        vectors++;
        if (rd[3:0] !== 4'b1110 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL zero done: got %b irq=%b want 1110 irq=1",
                     rd[3:0], irq);
        end
        cpu_write(2'd0, 32'h1);
        cpu_read(2'd0, rd);
        vectors++;
        if (rd[3:0] !== 4'b0011 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL rearm from done: got %b irq=%b want 0011 irq=0",
                     rd[3:0], irq);
        end
        cpu_write(2'd0, 32'h4);
        cpu_write(2'd0, 32'h8);
        cpu_read(2'd0, rd);
        vectors++;
        if (rd[3:0] !== 4'b1000 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL zero ack: got %b irq=%b want 1000 irq=0",
                     rd[3:0], irq);
        end
    endtask

    task automatic test_reset_mid();
        cpu_write(2'd1, 5);
        cpu_write(2'd0, 32'h1);
        cpu_write(2'd0, 32'h4);
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL pre-reset out: got %b/%h want 1/deadbeef",
                     out_valid, out_data);
        end
        reset    = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL mid reset: got ov=%b irq=%b want 0/0",
                     out_valid, irq);
        end
        reset = 1'b0;
        @(negedge clock);
        cpu_read(2'd3, rd);
        vectors++;
        if (rd !== 32'd0) begin
            miscompares++;
            $display("FAIL reset count: got %0d want 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decim();
        test_overflow();
        test_back_to_back();
        test_ext_trig();
        test_abort();
        test_zero();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
